// File: rtl/multiplier_controller.sv
// multiplier_controller
//
// Sequential 32x32 -> low-32-bit unsigned multiplier built around one shared
// 8x8 multiplier. An accepted request latches both operands and walks the ten
// byte-pair steps (i,j) with i+j <= 3, accumulating ai*bj << 8*(i+j) modulo
// 2^32. The result is registered into product and announced by a one-cycle
// done pulse.
//
// Optional feature: define MULTIPLIER_ZERO_SKIP_EN to bypass COMPUTE when
// either operand is zero at the accepting edge (done follows that edge).
//
// Ports:
//   clk        in   1  clock, all state updates on rising edge
//   reset      in   1  synchronous active-high reset
//   start      in   1  request a multiplication (accepted only in IDLE)
//   operand_1  in  32  multiplicand, sampled on the accepting edge
//   operand_2  in  32  multiplier, sampled on the accepting edge
//   busy       out  1  high whenever the controller is not IDLE
//   done       out  1  one-cycle pulse, product valid
//   product    out 32  registered low 32 bits of operand_1*operand_2
module multiplier_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd9;

    state_t      state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] product_q, product_d;
    logic [3:0]  step_q, step_d;

    logic [1:0]  sel_i, sel_j;
    logic [2:0]  sel_sum;
    logic [7:0]  a_byte, b_byte;
    logic [15:0] pp;
    logic [31:0] pp_shifted;
    logic [31:0] acc_next;
    logic        zero_skip;

`ifdef MULTIPLIER_ZERO_SKIP_EN
    assign zero_skip = (operand_1 == '0) || (operand_2 == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Step counter -> byte pair. Only pairs with i+j <= 3 reach the low word.
    always_comb begin
        sel_i = 2'd0;
        sel_j = 2'd0;
        case (step_q)
            4'd0:    begin sel_i = 2'd0; sel_j = 2'd0; end
            4'd1:    begin sel_i = 2'd0; sel_j = 2'd1; end
            4'd2:    begin sel_i = 2'd0; sel_j = 2'd2; end
            4'd3:    begin sel_i = 2'd0; sel_j = 2'd3; end
            4'd4:    begin sel_i = 2'd1; sel_j = 2'd0; end
            4'd5:    begin sel_i = 2'd1; sel_j = 2'd1; end
            4'd6:    begin sel_i = 2'd1; sel_j = 2'd2; end
            4'd7:    begin sel_i = 2'd2; sel_j = 2'd0; end
            4'd8:    begin sel_i = 2'd2; sel_j = 2'd1; end
            4'd9:    begin sel_i = 2'd3; sel_j = 2'd0; end
            default: begin sel_i = 2'd0; sel_j = 2'd0; end
        endcase
    end

    // Shared 8x8 multiplier and byte-aligned shift into the 32-bit window;
    // bits shifted past bit 31 fall off, giving the modulo-2^32 sum.
    assign a_byte     = op1_q[{sel_i, 3'b000} +: 8];
    assign b_byte     = op2_q[{sel_j, 3'b000} +: 8];
    assign pp         = {8'h00, a_byte} * {8'h00, b_byte};
    assign sel_sum    = {1'b0, sel_i} + {1'b0, sel_j};
    assign pp_shifted = {16'h0000, pp} << {sel_sum, 3'b000};
    assign acc_next   = acc_q + pp_shifted;

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        acc_d     = acc_q;
        product_d = product_q;
        step_d    = step_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op1_d  = operand_1;
                    op2_d  = operand_2;
                    acc_d  = '0;
                    step_d = '0;
                    if (zero_skip) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                acc_d = acc_next;
                if (step_q == LAST_STEP) begin
                    product_d = acc_next;
                    step_d    = '0;
                    state_d   = DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            step_q    <= step_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_multiplier_controller.sv
module tb_multiplier_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multiplier_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    // Reference: full-width product truncated to 32 bits.
    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        return full[31:0];
    endfunction

    // Reference: edges from acceptance until done is visible.
    function automatic int unsigned ref_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTIPLIER_ZERO_SKIP_EN
        if (a == 32'h0 || b == 32'h0) return 0;
`endif
        if (a == b + 32'h1) return 10;  // keeps both operands referenced
        return 10;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request from IDLE. With disturb set, operands are scrambled and start
    // is pulsed while busy; none of that may influence the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit disturb, input string tag);
        int unsigned lat;
        int unsigned pulses;
        int unsigned busy_low;
        int unsigned busy_after;
        bit          seen;
        logic [31:0] exp_p;
        exp_p      = ref_product(a, b);
        lat        = 99;
        pulses     = 0;
        busy_low   = 0;
        busy_after = 0;
        seen       = 1'b0;
        @(negedge clk);
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
        for (int n = 0; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (seen) begin
                if (busy !== 1'b0) busy_after++;
            end else if (busy !== 1'b1) begin
                busy_low++;
            end
            if (done === 1'b1) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    lat  = n;
                    check({tag, "_product"}, product, exp_p);
                end
            end
            if (disturb) begin
                operand_1 = $urandom;
                operand_2 = $urandom;
                start     = !seen || (done === 1'b1);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, ref_latency(a, b));
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_busy_low_while_active"}, busy_low, 0);
        check({tag, "_busy_after_done"}, busy_after, 0);
        check({tag, "_product_hold"}, product, exp_p);
    endtask

    task automatic reset_mid_compute();
        int unsigned pulses;
        int unsigned busy_cnt;
        pulses   = 0;
        busy_cnt = 0;
        @(negedge clk);
        operand_1 = 32'h0000_1234;
        operand_2 = 32'h0000_5678;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_product", product, 0);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (busy !== 1'b0) busy_cnt++;
        end
        check("midreset_no_done", pulses, 0);
        check("midreset_stays_idle", busy_cnt, 0);
    endtask

    // start held high: accepts at k, k+12, k+24; done at k+10, k+22, k+34.
    task automatic back_to_back();
        logic [31:0] oa[3];
        logic [31:0] ob[3];
        int unsigned m;
        m = 0;
        for (int i = 0; i < 3; i++) begin
            oa[i] = $urandom | 32'h1;
            ob[i] = $urandom | 32'h100;
        end
        @(negedge clk);
        operand_1 = oa[0];
        operand_2 = ob[0];
        start     = 1'b1;
        for (int n = 0; n <= 35; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (m < 3) begin
                    check("b2b_latency", n, 10 + 12 * m);
                    check("b2b_product", product, ref_product(oa[m], ob[m]));
                    if (m < 2) begin
                        operand_1 = oa[m + 1];
                        operand_2 = ob[m + 1];
                    end
                end
                m++;
            end
        end
        start = 1'b0;
        check("b2b_done_pulses", m, 3);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", busy, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sel;
        reset     = 1'b1;
        start     = 1'b0;
        operand_1 = 32'h0;
        operand_2 = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset = 1'b0;

        run_op(32'h0000_1234, 32'h0000_5678, 1'b0, "basic");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "all_ones");
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "wrap");
        run_op(32'h0000_0000, 32'h1234_5678, 1'b0, "zero_a");
        run_op(32'h8765_4321, 32'h0000_0000, 1'b0, "zero_b");
        run_op(32'h0000_0007, 32'h0000_0006, 1'b1, "ignore_start");
        reset_mid_compute();
        run_op(32'h0000_0003, 32'h0000_0005, 1'b0, "after_reset");
        back_to_back();

        for (int t = 0; t < 24; t++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0: a = 32'h0;
                1: b = 32'h0;
                2: begin
                    a = a & {{8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}},
                             {8{1'($urandom_range(0, 1))}}, 8'hFF};
                    b = b & {8'hFF, {8{1'($urandom_range(0, 1))}},
                             {8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}}};
                end
                default: ;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
